// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter granting N_REQ byte requesters access to one UART transmitter,
// with a post-reset idle-line guard and a watchdog on each transmitted byte.
module uart_tx_arbiter #(
  parameter int unsigned N_REQ        = 4,
  parameter int unsigned TIMEOUT_CLKS = 4096,
  parameter int unsigned GUARD_CLKS   = 256
) (
  input  logic               i_Clock,
  input  logic               i_Rst_n,
  input  logic [N_REQ-1:0]   i_Req_Valid,
  input  logic [8*N_REQ-1:0] i_Req_Byte,
  input  logic [N_REQ-1:0]   i_Req_Last,
  output logic [N_REQ-1:0]   o_Req_Ack,
  output logic [N_REQ-1:0]   o_Grant,
  output logic               o_TX_DV,
  output logic [7:0]         o_TX_Byte,
  input  logic               i_TX_Active,
  input  logic               i_TX_Done,
  output logic               o_Busy,
  output logic               o_Timeout
);

  localparam int unsigned IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned GW = $clog2(GUARD_CLKS + 1);
  localparam int unsigned WW = 16;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_SEND,
    ST_WAIT,
    ST_HOLD
  } state_t;

  state_t           r_state, w_state;
  logic [IW-1:0]    r_ptr, w_ptr;
  logic [IW-1:0]    r_owner, w_owner;
  logic             r_last, w_last;
  logic [GW-1:0]    r_guard_cnt, w_guard_cnt;
  logic [WW-1:0]    r_wd_cnt, w_wd_cnt;
  logic [N_REQ-1:0] r_ack, w_ack;
  logic [N_REQ-1:0] r_grant, w_grant;
  logic             r_tx_dv, w_tx_dv;
  logic [7:0]       r_tx_byte, w_tx_byte;
  logic             r_busy, w_busy;
  logic             r_timeout, w_timeout;

  logic             w_win_found;
  logic [IW-1:0]    w_win_idx;
  logic [7:0]       w_win_byte;
  logic             w_win_last;
  logic [7:0]       w_own_byte;
  logic             w_own_last;
  logic [IW-1:0]    w_ptr_adv;
  logic             w_wd_hit;

  // Round-robin search: first valid requester at or above the pointer, wrapping.
  always_comb begin
    logic [IW-1:0] v_cand;
    v_cand      = '0;
    w_win_found = 1'b0;
    w_win_idx   = r_ptr;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      v_cand = IW'((32'(r_ptr) + i) % N_REQ);
      if (!w_win_found && i_Req_Valid[v_cand]) begin
        w_win_found = 1'b1;
        w_win_idx   = v_cand;
      end
    end
  end

  assign w_win_byte = i_Req_Byte[{w_win_idx, 3'b000} +: 8];
  assign w_win_last = i_Req_Last[w_win_idx];
  assign w_own_byte = i_Req_Byte[{r_owner, 3'b000} +: 8];
  assign w_own_last = i_Req_Last[r_owner];
  assign w_ptr_adv  = (r_owner == IW'(N_REQ - 1)) ? '0 : r_owner + IW'(1);
  // Watchdog counts from 0 on the first WAIT/HOLD cycle; expiry is judged on its last count.
  assign w_wd_hit   = (r_wd_cnt == WW'(TIMEOUT_CLKS - 1));

  always_comb begin
    w_state     = r_state;
    w_ptr       = r_ptr;
    w_owner     = r_owner;
    w_last      = r_last;
    w_guard_cnt = r_guard_cnt;
    w_wd_cnt    = r_wd_cnt;
    w_ack       = '0;
    w_grant     = r_grant;
    w_tx_dv     = 1'b0;
    w_tx_byte   = r_tx_byte;
    w_timeout   = 1'b0;
    case (r_state)
      ST_INIT: begin
        if (i_TX_Active) begin
          w_guard_cnt = '0;
        end else if (r_guard_cnt == GW'(GUARD_CLKS - 1)) begin
          w_guard_cnt = '0;
          w_state     = ST_IDLE;
        end else begin
          w_guard_cnt = r_guard_cnt + GW'(1);
        end
      end
      ST_IDLE: begin
        if (!i_TX_Active && w_win_found) begin
          w_owner   = w_win_idx;
          w_grant   = N_REQ'(1) << w_win_idx;
          w_ack     = N_REQ'(1) << w_win_idx;
          w_tx_dv   = 1'b1;
          w_tx_byte = w_win_byte;
          w_last    = w_win_last;
          w_state   = ST_SEND;
        end
      end
      ST_SEND: begin
        w_wd_cnt = '0;
        w_state  = ST_WAIT;
      end
      ST_WAIT: begin
        if (i_TX_Done) begin
          if (r_last) begin
            w_grant = '0;
            w_ptr   = w_ptr_adv;
            w_state = ST_IDLE;
          end else begin
            w_wd_cnt = '0;
            w_state  = ST_HOLD;
          end
        end else if (w_wd_hit) begin
          w_timeout = 1'b1;
          w_grant   = '0;
          w_ptr     = w_ptr_adv;
          w_state   = ST_IDLE;
        end else begin
          w_wd_cnt = r_wd_cnt + WW'(1);
        end
      end
      ST_HOLD: begin
        if (i_Req_Valid[r_owner]) begin
          w_ack     = N_REQ'(1) << r_owner;
          w_tx_dv   = 1'b1;
          w_tx_byte = w_own_byte;
          w_last    = w_own_last;
          w_state   = ST_SEND;
        end else if (w_wd_hit) begin
          w_timeout = 1'b1;
          w_grant   = '0;
          w_ptr     = w_ptr_adv;
          w_state   = ST_IDLE;
        end else begin
          w_wd_cnt = r_wd_cnt + WW'(1);
        end
      end
      default: begin
        w_state = ST_INIT;
      end
    endcase
    w_busy = (w_state != ST_IDLE);
  end

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      r_state     <= ST_INIT;
      r_ptr       <= '0;
      r_owner     <= '0;
      r_last      <= 1'b0;
      r_guard_cnt <= '0;
      r_wd_cnt    <= '0;
      r_ack       <= '0;
      r_grant     <= '0;
      r_tx_dv     <= 1'b0;
      r_tx_byte   <= '0;
      r_busy      <= 1'b1;
      r_timeout   <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_ptr       <= w_ptr;
      r_owner     <= w_owner;
      r_last      <= w_last;
      r_guard_cnt <= w_guard_cnt;
      r_wd_cnt    <= w_wd_cnt;
      r_ack       <= w_ack;
      r_grant     <= w_grant;
      r_tx_dv     <= w_tx_dv;
      r_tx_byte   <= w_tx_byte;
      r_busy      <= w_busy;
      r_timeout   <= w_timeout;
    end
  end

  assign o_Req_Ack = r_ack;
  assign o_Grant   = r_grant;
  assign o_TX_DV   = r_tx_dv;
  assign o_TX_Byte = r_tx_byte;
  assign o_Busy    = r_busy;
  assign o_Timeout = r_timeout;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: packet-level round-robin model, transmitter model,
// and a monitor that checks every DV/ack and timeout against expectations.
module tb_uart_tx_arbiter;

  localparam int unsigned N     = 4;
  localparam int unsigned T     = 64;
  localparam int unsigned G     = 16;
  localparam int          FRAME = 44;

  typedef struct packed {
    logic [7:0] k;
    logic [7:0] b;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req_valid;
  logic [8*N-1:0] req_byte;
  logic [N-1:0]   req_last;
  logic [N-1:0]   ack;
  logic [N-1:0]   grant;
  logic           tx_dv;
  logic [7:0]     tx_byte;
  logic           tx_active;
  logic           tx_force;
  logic           tx_active_i;
  logic           tx_done;
  logic           busy;
  logic           timeout;

  assign tx_active_i = tx_active | tx_force;

  uart_tx_arbiter #(.N_REQ(N), .TIMEOUT_CLKS(T), .GUARD_CLKS(G)) dut (
    .i_Clock    (clk),
    .i_Rst_n    (rst_n),
    .i_Req_Valid(req_valid),
    .i_Req_Byte (req_byte),
    .i_Req_Last (req_last),
    .o_Req_Ack  (ack),
    .o_Grant    (grant),
    .o_TX_DV    (tx_dv),
    .o_TX_Byte  (tx_byte),
    .i_TX_Active(tx_active_i),
    .i_TX_Done  (tx_done),
    .o_Busy     (busy),
    .o_Timeout  (timeout)
  );

  always #5 clk = ~clk;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t exp_q[$];
  int   exp_to = 0;
  int   n_to_seen = 0;
  int   dv_in_guard = 0;
  logic in_guard = 1'b0;

  logic [8:0] rq_mem [N][256];
  int         rq_head [N];
  int         rq_tail [N];
  int         m_ptr = 0;

  int   tx_cnt = 0;
  int   tx_frame = FRAME;
  logic tx_hang = 1'b0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  // One clock of stimulus: transmitter model and requester drivers, updated at negedge.
  task automatic tick();
    @(negedge clk);
    tx_done = 1'b0;
    if (tx_dv && !tx_active) begin
      tx_active = 1'b1;
      tx_cnt    = tx_frame;
    end else if (tx_active) begin
      tx_cnt--;
      if (tx_cnt == 0) begin
        tx_active = 1'b0;
        if (tx_hang) tx_hang = 1'b0;
        else         tx_done = 1'b1;
        tx_frame = FRAME;
      end
    end
    for (int k = 0; k < N; k++) begin
      if (ack[k] && rq_head[k] != rq_tail[k]) rq_head[k]++;
      if (rq_head[k] != rq_tail[k]) begin
        req_valid[k]       = 1'b1;
        req_byte[8*k +: 8] = rq_mem[k][rq_head[k]][7:0];
        req_last[k]        = rq_mem[k][rq_head[k]][8];
      end else begin
        req_valid[k]       = 1'b0;
        req_byte[8*k +: 8] = 8'h00;
        req_last[k]        = 1'b0;
      end
    end
  endtask

  task automatic load(input int k, input logic [7:0] b, input logic last);
    rq_mem[k][rq_tail[k]] = {last, b};
    rq_tail[k]++;
  endtask

  // Packet-level reference: whole packets served in round-robin order from the model pointer.
  function automatic void plan();
    int   h [N];
    int   k;
    bit   found;
    logic [8:0] item;
    for (int i = 0; i < N; i++) h[i] = rq_head[i];
    forever begin
      found = 1'b0;
      k = 0;
      for (int i = 0; i < N; i++) begin
        if (!found && h[(m_ptr + i) % N] != rq_tail[(m_ptr + i) % N]) begin
          found = 1'b1;
          k = (m_ptr + i) % N;
        end
      end
      if (!found) break;
      do begin
        item = rq_mem[k][h[k]];
        h[k]++;
        exp_q.push_back('{k: 8'(k), b: item[7:0]});
      end while (!item[8] && h[k] != rq_tail[k]);
      m_ptr = (k + 1) % N;
    end
  endfunction

  task automatic drain(input string name, input int budget);
    int cnt;
    cnt = 0;
    while ((exp_q.size() != 0 || busy || tx_active) && cnt < budget) begin
      tick();
      cnt++;
    end
    n_tests++;
    if (cnt >= budget) begin
      n_fail++;
      $display("FAIL drain_%s: %0d bytes still expected, busy=%b after %0d cycles", name, exp_q.size(), busy, cnt);
    end
  endtask

  task automatic random_phase(input string name);
    int nb;
    nb = 0;
    for (int k = 0; k < N; k++) begin
      int np;
      np = $urandom_range(0, 2);
      for (int p = 0; p < np; p++) begin
        int len;
        len = $urandom_range(1, 3);
        for (int j = 0; j < len; j++) begin
          load(k, 8'($urandom), (j == len - 1));
          nb++;
        end
      end
    end
    plan();
    drain(name, nb * (FRAME + 8) + 100);
  endtask

  // Monitor: sampled 1ns after each rising edge, pops the scoreboard on every DV/ack.
  initial begin
    int   mcyc;
    int   last_dv;
    logic prev_dv;
    exp_t e;
    logic [N-1:0] want_ack;
    mcyc = 0;
    last_dv = 0;
    prev_dv = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      mcyc++;
      if (rst_n) begin
        if (tx_dv || ack != '0) begin
          n_tests++;
          if (in_guard) dv_in_guard++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL dv_unexpected: got dv=%b ack=%b byte=%h, want no transfer", tx_dv, ack, tx_byte);
          end else begin
            e = exp_q.pop_front();
            want_ack = N'(1) << e.k;
            if (!tx_dv || tx_byte !== e.b || ack !== want_ack || grant !== want_ack || prev_dv || tx_active_i) begin
              n_fail++;
              $display("FAIL dv_check: got dv=%b byte=%h ack=%b grant=%b prev_dv=%b active=%b, want byte=%h ack/grant=%b",
                       tx_dv, tx_byte, ack, grant, prev_dv, tx_active_i, e.b, want_ack);
            end
          end
          last_dv = mcyc;
        end
        if (timeout) begin
          n_tests++;
          n_to_seen++;
          if (exp_to == 0 || (mcyc - last_dv) != int'(T + 1) || grant !== '0) begin
            n_fail++;
            $display("FAIL timeout_check: got delay=%0d grant=%b expected_left=%0d, want delay=%0d grant=0",
                     mcyc - last_dv, grant, exp_to, T + 1);
          end else begin
            exp_to--;
          end
        end
        prev_dv = tx_dv;
      end else begin
        prev_dv = 1'b0;
      end
    end
  end

  initial begin
    #(800_000);
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cnt;
    int to_before;
    req_valid = '0;
    req_byte  = '0;
    req_last  = '0;
    tx_active = 1'b0;
    tx_force  = 1'b0;
    tx_done   = 1'b0;
    for (int k = 0; k < N; k++) begin
      rq_head[k] = 0;
      rq_tail[k] = 0;
    end

    // Reset values, then guard interval on a quiet line.
    tick();
    tick();
    check("reset_outputs", 64'({grant, ack, tx_dv, tx_byte, busy, timeout}), 64'({4'b0, 4'b0, 1'b0, 8'h00, 1'b1, 1'b0}));
    in_guard = 1'b1;
    rst_n = 1'b1;
    cnt = 0;
    while (busy && cnt < 10 * G) begin
      tick();
      cnt++;
    end
    in_guard = 1'b0;
    check("guard_len", 64'(cnt), 64'(G));
    check("no_dv_in_guard", 64'(dv_in_guard), 64'd0);

    // Single byte from requester 0.
    load(0, 8'h55, 1'b1);
    plan();
    drain("single", 200);
    check("single_release", 64'({grant, busy}), 64'd0);

    // All four requesters, requester 0 with two packets.
    for (int k = 0; k < N; k++) load(k, 8'(8'h10 + k), 1'b1);
    load(0, 8'h20, 1'b1);
    plan();
    drain("all_four", 600);

    // Multi-byte packet from requester 2 blocks requester 0.
    load(2, 8'h01, 1'b0);
    load(2, 8'h02, 1'b0);
    load(2, 8'h03, 1'b1);
    load(0, 8'hA0, 1'b1);
    plan();
    drain("packet_hold", 600);

    // Sole requester repeatedly wins.
    for (int j = 0; j < 3; j++) load(1, 8'(8'h70 + j), 1'b1);
    plan();
    drain("sole", 400);

    // Done withheld: one watchdog timeout, then next requester served.
    tx_hang = 1'b1;
    exp_to = 1;
    load(0, 8'hE1, 1'b1);
    load(1, 8'hE2, 1'b1);
    plan();
    drain("timeout", 600);
    check("timeout_seen", 64'(exp_to), 64'd0);

    // Done on the expiry cycle: done wins, no timeout.
    to_before = n_to_seen;
    tx_frame = T;
    load(2, 8'hC1, 1'b1);
    load(3, 8'hC2, 1'b1);
    plan();
    drain("coincident", 600);
    check("coincident_no_timeout", 64'(n_to_seen), 64'(to_before));

    for (int p = 0; p < 6; p++) random_phase($sformatf("rand%0d", p));

    // Reset during WAIT with the transmitter still busy for 500 clocks.
    load(3, 8'h3C, 1'b1);
    plan();
    cnt = 0;
    while (!tx_dv && cnt < 300) begin
      tick();
      cnt++;
    end
    check("reset_test_dv_issued", 64'(cnt < 300), 64'd1);
    repeat (3) tick();
    rst_n    = 1'b0;
    tx_force = 1'b1;
    in_guard = 1'b1;
    dv_in_guard = 0;
    for (int k = 0; k < N; k++) rq_head[k] = rq_tail[k];
    exp_q.delete();
    m_ptr = 0;
    #1;
    check("midwait_reset_outputs", 64'({grant, ack, tx_dv, tx_byte, busy, timeout}), 64'({4'b0, 4'b0, 1'b0, 8'h00, 1'b1, 1'b0}));
    tick();
    tick();
    rst_n = 1'b1;
    load(1, 8'hB1, 1'b1);
    repeat (500) tick();
    check("busy_while_line_active", 64'(busy), 64'd1);
    tx_force = 1'b0;
    cnt = 0;
    while (busy && cnt < 10 * G) begin
      tick();
      cnt++;
    end
    in_guard = 1'b0;
    check("guard_after_reset", 64'(cnt), 64'(G));
    check("no_dv_in_guard2", 64'(dv_in_guard), 64'd0);
    plan();
    drain("after_reset", 200);
    random_phase("rand_post");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
